// File: rtl/mips32_mem_pkg.sv
// Shared constants and response record for the MIPS32 memory responder.
// Holds RAM geometry defaults, latency bounds, port ids and the range check.
package mips32_mem_pkg;

    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 4;
    localparam int LAT_DEF    = 1;
    localparam int STARVE_DEF = 4;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // A word address is out of range when any bit above the index is set.
    function automatic logic addr_oor(input logic [31:0] a, input int aw);
        return (a >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Fetch + load/store request/response bundle between core and memory.
// master = core side (drives requests), slave = responder side.
interface mips32_mem_responder_if;

    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;

    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

endinterface

// File: rtl/mips32_mem_lat_pipe.sv
// LATENCY-stage valid+payload delay line; async clear drops in-flight items.
// Ports: clk, rst_n, i_valid/i_data in, o_valid/o_data out LATENCY edges later.
module mips32_mem_lat_pipe
    import mips32_mem_pkg::*;
#(
    parameter int LATENCY = LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  rsp_t i_data,
    output logic o_valid,
    output rsp_t o_data
);

    logic [LATENCY-1:0] r_valid;
    rsp_t               r_data [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mips32_mem_responder.sv
// Shared single-port RAM serving IF fetch and MEM load/store with in-order,
// fixed-latency responses. Ports: clk, rst_n, bus (slave modport).
// Optional macro MEM_OOR_ERR_EN: flag and suppress accesses with addr[31:AW]!=0.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int LATENCY    = LAT_DEF,
    parameter int STARVE_MAX = STARVE_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    mips32_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 2);

    logic [CW-1:0] r_starve;
    logic [31:0]   r_mem [DEPTH];

    logic          w_force_i;
    logic          w_d_ready;
    logic          w_i_ready;
    logic          w_d_grant;
    logic          w_i_grant;
    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    rsp_t          w_rsp;
    logic          w_out_valid;
    rsp_t          w_out;
    logic          w_i_hit;
    logic          w_d_hit;

    // Data port wins unless fetch has waited through STARVE_MAX data grants.
    assign w_force_i = (r_starve == CW'(STARVE_MAX));
    assign w_d_ready = !(w_force_i && bus.i_req_valid);
    assign w_i_ready = !bus.d_req_valid || w_force_i;
    assign w_d_grant = bus.d_req_valid && w_d_ready;
    assign w_i_grant = bus.i_req_valid && w_i_ready;

    assign bus.d_req_ready = w_d_ready;
    assign bus.i_req_ready = w_i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!bus.i_req_valid || w_i_grant) begin
            r_starve <= '0;
        end else if (w_d_grant && !w_force_i) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_addr = w_d_grant ? bus.d_req_addr : bus.i_req_addr;
    assign w_idx  = w_addr[AW-1:0];

`ifdef MEM_OOR_ERR_EN
    assign w_oor = addr_oor(w_addr, AW);
`else
    // Upper address bits are ignored: the RAM wraps modulo DEPTH.
    logic [31-AW:0] w_unused_hi;
    assign w_unused_hi = w_addr[31:AW];
    assign w_oor       = 1'b0;
`endif

    // RAM has no reset; writes only while out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_d_grant && bus.d_req_we && !w_oor) begin
            r_mem[w_idx] <= bus.d_req_wdata;
        end
    end

    // Stage 0 of the pipe captures the read at the acceptance edge.
    always_comb begin
        w_rsp      = '0;
        w_rsp.port = w_d_grant ? PORT_D : PORT_I;
        w_rsp.err  = w_oor;
        if (!w_oor && !(w_d_grant && bus.d_req_we)) begin
            w_rsp.rdata = r_mem[w_idx];
        end
    end

    mips32_mem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_d_grant || w_i_grant),
        .i_data  (w_rsp),
        .o_valid (w_out_valid),
        .o_data  (w_out)
    );

    // Outputs stay zero except during the response pulse of their port.
    assign w_i_hit = w_out_valid && (w_out.port == PORT_I);
    assign w_d_hit = w_out_valid && (w_out.port == PORT_D);

    assign bus.i_rsp_valid = w_i_hit;
    assign bus.i_rsp_rdata = w_i_hit ? w_out.rdata : 32'd0;
    assign bus.d_rsp_valid = w_d_hit;
    assign bus.d_rsp_rdata = w_d_hit ? w_out.rdata : 32'd0;

`ifdef MEM_OOR_ERR_EN
    assign bus.i_rsp_err = w_i_hit && w_out.err;
    assign bus.d_rsp_err = w_d_hit && w_out.err;
`else
    logic w_unused_err;
    assign w_unused_err  = w_out.err;
    assign bus.i_rsp_err = 1'b0;
    assign bus.d_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: LATENCY=1 and LATENCY=3 instances in lockstep
// against a transaction-level model, plus directed vectors and corner sequences.
module tb_mips32_mem_responder;
    import mips32_mem_pkg::*;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips32_mem_responder_if bus1();
    mips32_mem_responder_if bus3();

    assign bus3.i_req_valid = bus1.i_req_valid;
    assign bus3.i_req_addr  = bus1.i_req_addr;
    assign bus3.d_req_valid = bus1.d_req_valid;
    assign bus3.d_req_we    = bus1.d_req_we;
    assign bus3.d_req_addr  = bus1.d_req_addr;
    assign bus3.d_req_wdata = bus1.d_req_wdata;

    mips32_mem_responder #(
        .DEPTH(1024), .LATENCY(1), .STARVE_MAX(STARVE)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    mips32_mem_responder #(
        .DEPTH(1024), .LATENCY(3), .STARVE_MAX(STARVE)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          v;
        bit          d;
        logic [31:0] rd;
        bit          er;
    } exp_t;

    typedef struct {
        bit          iv;
        logic [31:0] ia;
        bit          dv;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          ep;
        logic [31:0] erd;
        bit          eer;
    } vec_t;

    logic [31:0] mem [1024];
    exp_t        hist [8];
    int          waited;
    int          E;
    bit          obs_ir;
    bit          obs_dr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 8; i++) begin
            hist[i].v  = 1'b0;
            hist[i].d  = 1'b0;
            hist[i].rd = 32'd0;
            hist[i].er = 1'b0;
        end
    endtask

    task automatic chk_rsp(input string nm, input exp_t x,
                           input logic iv, input logic [31:0] ird, input logic ie,
                           input logic dv, input logic [31:0] drd, input logic de);
        bit ei;
        bit ed;
        ei = x.v && !x.d;
        ed = x.v && x.d;
        chk({nm, ".flags"}, 32'({iv, ie, dv, de}), 32'({ei, ei && x.er, ed, ed && x.er}));
        chk({nm, ".i_rdata"}, ird, ei ? x.rd : 32'd0);
        chk({nm, ".d_rdata"}, drd, ed ? x.rd : 32'd0);
    endtask

    task automatic chk_both();
        chk_rsp("lat1", hist[E % 8],
                bus1.i_rsp_valid, bus1.i_rsp_rdata, bus1.i_rsp_err,
                bus1.d_rsp_valid, bus1.d_rsp_rdata, bus1.d_rsp_err);
        chk_rsp("lat3", hist[(E - 2) % 8],
                bus3.i_rsp_valid, bus3.i_rsp_rdata, bus3.i_rsp_err,
                bus3.d_rsp_valid, bus3.d_rsp_rdata, bus3.d_rsp_err);
    endtask

    task automatic drive(input bit iv, input logic [31:0] ia, input bit dv,
                         input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        bus1.i_req_valid = iv;
        bus1.i_req_addr  = ia;
        bus1.d_req_valid = dv;
        bus1.d_req_we    = dwe;
        bus1.d_req_addr  = da;
        bus1.d_req_wdata = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // One clock: check readies, commit the model at the edge, check responses.
    task automatic cycle();
        bit          forced;
        bit          gd;
        bit          gi;
        bit          bad;
        logic [31:0] a;
        exp_t        n;
        #1;
        forced = (waited >= STARVE);
        obs_dr = bus1.d_req_ready;
        obs_ir = bus1.i_req_ready;
        chk("ready1", 32'({obs_ir, obs_dr}),
            32'({!bus1.d_req_valid || forced, !(forced && bus1.i_req_valid)}));
        chk("ready3", 32'({bus3.i_req_ready, bus3.d_req_ready}), 32'({obs_ir, obs_dr}));
        @(posedge clk);
        gd = bus1.d_req_valid && !(forced && bus1.i_req_valid);
        gi = !gd && bus1.i_req_valid;
        n.v = gd || gi;
        n.d = gd;
        n.rd = 32'd0;
        a = gd ? bus1.d_req_addr : bus1.i_req_addr;
`ifdef MEM_OOR_ERR_EN
        bad = (a >= 32'd1024);
`else
        bad = 1'b0;
`endif
        n.er = n.v && bad;
        if (n.v && !bad) begin
            if (gd && bus1.d_req_we) mem[a % 1024] = bus1.d_req_wdata;
            else n.rd = mem[a % 1024];
        end
        if (!bus1.i_req_valid || gi) waited = 0;
        else if (gd && waited < STARVE) waited++;
        E++;
        hist[E % 8] = n;
        @(negedge clk);
        chk_both();
    endtask

    task automatic do_reset();
        exp_t z;
        z.v = 1'b0; z.d = 1'b0; z.rd = 32'd0; z.er = 1'b0;
        idle();
        rst_n = 1'b0;
        #1;
        chk_rsp("rst1", z, bus1.i_rsp_valid, bus1.i_rsp_rdata, bus1.i_rsp_err,
                bus1.d_rsp_valid, bus1.d_rsp_rdata, bus1.d_rsp_err);
        chk_rsp("rst3", z, bus3.i_rsp_valid, bus3.i_rsp_rdata, bus3.i_rsp_err,
                bus3.d_rsp_valid, bus3.d_rsp_rdata, bus3.d_rsp_err);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_rsp("rst3b", z, bus3.i_rsp_valid, bus3.i_rsp_rdata, bus3.i_rsp_err,
                bus3.d_rsp_valid, bus3.d_rsp_rdata, bus3.d_rsp_err);
        rst_n = 1'b1;
        waited = 0;
        clear_hist();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(15, 0);
        if (r == 0) return 32'h400 | 32'($urandom_range(31, 0));
        if (r == 1) return ($urandom & 32'hFFFFFC00) | 32'($urandom_range(31, 0));
        return 32'($urandom_range(31, 0));
    endfunction

    vec_t tbl [8];

    initial begin
        idle();
        clear_hist();
        waited = 0;
        E = 8;
        repeat (3) @(negedge clk);
        chk_both();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b1, 32'(a), 32'hA5A50000 | 32'(a));
            cycle();
        end

        tbl[0] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h2A, 1'b1, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'h2A, 1'b0};
        tbl[2] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 32'hFC000000, 1'b1, 32'd0, 1'b0};
        tbl[3] = '{1'b1, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hFC000000, 1'b0};
`ifdef MEM_OOR_ERR_EN
        tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 1'b1, 32'd0, 1'b1};
        tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'h405, 32'hDEAD, 1'b1, 32'd0, 1'b1};
        tbl[6] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'h2A, 1'b0};
`else
        tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 1'b1, 32'hA5A50000, 1'b0};
        tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'h405, 32'hDEAD, 1'b1, 32'd0, 1'b0};
        tbl[6] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'hDEAD, 1'b0};
`endif
        tbl[7] = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hA5A50001, 1'b0};

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].iv, tbl[k].ia, tbl[k].dv, tbl[k].dwe, tbl[k].da, tbl[k].dwd);
            cycle();
            chk($sformatf("vec%0d.flags", k),
                32'({bus1.i_rsp_valid, bus1.i_rsp_err, bus1.d_rsp_valid, bus1.d_rsp_err}),
                32'({!tbl[k].ep, !tbl[k].ep && tbl[k].eer, tbl[k].ep, tbl[k].ep && tbl[k].eer}));
            chk($sformatf("vec%0d.rdata", k),
                tbl[k].ep ? bus1.d_rsp_rdata : bus1.i_rsp_rdata, tbl[k].erd);
        end

        idle();
        cycle();
        drive(1'b1, 32'd2, 1'b1, 1'b0, 32'd3, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk($sformatf("starve%0d", k), 32'({obs_ir, obs_dr}),
                (k == 4) ? 32'd2 : 32'd1);
        end

        idle();
        cycle();
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 32'(j), 1'b0, 1'b0, 32'd0, 32'd0);
            cycle();
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("lat3_v%0d", j), 32'(bus3.i_rsp_valid), 32'd1);
            chk($sformatf("lat3_d%0d", j), bus3.i_rsp_rdata, 32'hA5A50000 | 32'(j));
            idle();
            cycle();
        end
        chk("lat3_end", 32'(bus3.i_rsp_valid), 32'd0);

        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);
        cycle();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        cycle();
        do_reset();
        repeat (4) begin
            idle();
            cycle();
        end

        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd9, 32'h12345678);
        cycle();
        do_reset();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
        cycle();
        chk("rst_store", bus1.d_rsp_rdata, 32'h12345678);

        for (int c = 0; c < 4000; c++) begin
            drive($urandom_range(3, 0) != 0, rand_addr(),
                  $urandom_range(2, 0) != 0, $urandom_range(1, 0) != 0,
                  rand_addr(), $urandom);
            if ($urandom_range(499, 0) == 0) do_reset();
            else cycle();
        end

        idle();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
